// File: rtl/nv_nvdla_sdp_rdma_arb.sv
// Round-robin read arbiter: merges SDP RDMA b/n/e read requests onto one MCIF port and routes in-order responses back.
// Define NVDLA_SDP_RDMA_ARB_PERF_EN to build the dp2reg_arb_stall counter; otherwise it reads as zero.
module nv_nvdla_sdp_rdma_arb #(
  parameter int TAG_DEPTH = 8
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        b_rd_req_valid,
  output logic        b_rd_req_ready,
  input  logic [46:0] b_rd_req_pd,
  input  logic        n_rd_req_valid,
  output logic        n_rd_req_ready,
  input  logic [46:0] n_rd_req_pd,
  input  logic        e_rd_req_valid,
  output logic        e_rd_req_ready,
  input  logic [46:0] e_rd_req_pd,
  output logic        b_rd_rsp_valid,
  input  logic        b_rd_rsp_ready,
  output logic [64:0] b_rd_rsp_pd,
  output logic        n_rd_rsp_valid,
  input  logic        n_rd_rsp_ready,
  output logic [64:0] n_rd_rsp_pd,
  output logic        e_rd_rsp_valid,
  input  logic        e_rd_rsp_ready,
  output logic [64:0] e_rd_rsp_pd,
  output logic        mc_rd_req_valid,
  input  logic        mc_rd_req_ready,
  output logic [46:0] mc_rd_req_pd,
  input  logic        mc_rd_rsp_valid,
  output logic        mc_rd_rsp_ready,
  input  logic [64:0] mc_rd_rsp_pd,
  input  logic        stall_clr,
  output logic [31:0] dp2reg_arb_stall
);

  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = TAG_DEPTH[AW:0];
  localparam logic [1:0] SRC_B = 2'd0;
  localparam logic [1:0] SRC_N = 2'd1;
  localparam logic [1:0] SRC_E = 2'd2;

  logic [2:0]    req_valid;
  logic [1:0]    rr_ptr;
  logic [1:0]    rr_pick;
  logic [1:0]    grant_src;
  logic [1:0]    lock_src;
  logic          locked;
  logic          grant_valid;
  logic [46:0]   grant_pd;
  logic          req_fire;
  logic [16:0]   tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   tag_cnt;
  logic          tag_full;
  logic          tag_empty;
  logic [1:0]    head_src;
  logic [14:0]   head_size;
  logic [14:0]   beat_cnt;
  logic [2:0]    route_sel;
  logic          route_ready;
  logic          rsp_fire;
  logic          tag_pop;

  assign req_valid = {e_rd_req_valid, n_rd_req_valid, b_rd_req_valid};

  // Search starts at the source after the last granted one.
  always_comb begin
    rr_pick = rr_ptr;
    case (rr_ptr)
      SRC_N:   rr_pick = req_valid[1] ? SRC_N : req_valid[2] ? SRC_E : req_valid[0] ? SRC_B : SRC_N;
      SRC_E:   rr_pick = req_valid[2] ? SRC_E : req_valid[0] ? SRC_B : req_valid[1] ? SRC_N : SRC_E;
      default: rr_pick = req_valid[0] ? SRC_B : req_valid[1] ? SRC_N : req_valid[2] ? SRC_E : SRC_B;
    endcase
  end

  assign grant_src = locked ? lock_src : rr_pick;

  always_comb begin
    grant_valid = 1'b0;
    grant_pd    = '0;
    case (grant_src)
      SRC_B:   begin grant_valid = b_rd_req_valid; grant_pd = b_rd_req_pd; end
      SRC_N:   begin grant_valid = n_rd_req_valid; grant_pd = n_rd_req_pd; end
      SRC_E:   begin grant_valid = e_rd_req_valid; grant_pd = e_rd_req_pd; end
      default: begin grant_valid = 1'b0;           grant_pd = '0;          end
    endcase
  end

  // Outputs are gated by reset so nothing leaks out while the core is held in reset.
  assign mc_rd_req_valid = nvdla_core_rstn & grant_valid & ~tag_full;
  assign mc_rd_req_pd    = nvdla_core_rstn ? grant_pd : '0;
  assign req_fire        = mc_rd_req_valid & mc_rd_req_ready;
  assign b_rd_req_ready  = req_fire & (grant_src == SRC_B);
  assign n_rd_req_ready  = req_fire & (grant_src == SRC_N);
  assign e_rd_req_ready  = req_fire & (grant_src == SRC_E);

  assign tag_full  = (tag_cnt == FULL_CNT);
  assign tag_empty = (tag_cnt == '0);
  assign head_src  = tag_mem[rd_ptr][16:15];
  assign head_size = tag_mem[rd_ptr][14:0];

  always_comb begin
    route_sel   = '0;
    route_ready = 1'b0;
    if (!tag_empty) begin
      case (head_src)
        SRC_B:   begin route_sel = 3'b001; route_ready = b_rd_rsp_ready; end
        SRC_N:   begin route_sel = 3'b010; route_ready = n_rd_rsp_ready; end
        SRC_E:   begin route_sel = 3'b100; route_ready = e_rd_rsp_ready; end
        default: begin route_sel = 3'b000; route_ready = 1'b0;           end
      endcase
    end
  end

  assign mc_rd_rsp_ready = route_ready;
  assign b_rd_rsp_valid  = route_sel[0] & mc_rd_rsp_valid;
  assign n_rd_rsp_valid  = route_sel[1] & mc_rd_rsp_valid;
  assign e_rd_rsp_valid  = route_sel[2] & mc_rd_rsp_valid;
  assign b_rd_rsp_pd     = route_sel[0] ? mc_rd_rsp_pd : '0;
  assign n_rd_rsp_pd     = route_sel[1] ? mc_rd_rsp_pd : '0;
  assign e_rd_rsp_pd     = route_sel[2] ? mc_rd_rsp_pd : '0;
  assign rsp_fire        = mc_rd_rsp_valid & mc_rd_rsp_ready;
  assign tag_pop         = rsp_fire & (beat_cnt == head_size);

  always_ff @(posedge nvdla_core_clk) begin
    if (req_fire) begin
      tag_mem[wr_ptr] <= {grant_src, grant_pd[46:32]};
    end
  end

  // A stalled handshake locks the grant so the MCIF sees a stable request.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rr_ptr   <= SRC_B;
      locked   <= 1'b0;
      lock_src <= SRC_B;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      locked <= mc_rd_req_valid & ~mc_rd_req_ready;
      if (mc_rd_req_valid && !mc_rd_req_ready) begin
        lock_src <= grant_src;
      end
      if (req_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        case (grant_src)
          SRC_B:   rr_ptr <= SRC_N;
          SRC_N:   rr_ptr <= SRC_E;
          default: rr_ptr <= SRC_B;
        endcase
      end
      if (tag_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({req_fire, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
      if (rsp_fire) begin
        beat_cnt <= tag_pop ? '0 : beat_cnt + 1'b1;
      end
    end
  end

`ifdef NVDLA_SDP_RDMA_ARB_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if ((|req_valid) && !req_fire && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign dp2reg_arb_stall = stall_cnt;
`else
  logic stall_clr_unused;
  assign stall_clr_unused = stall_clr;
  assign dp2reg_arb_stall = 32'd0;
`endif

endmodule

// File: doc/nv_nvdla_sdp_rdma_arb.md
NV_NVDLA_SDP_RDMA_ARB -- requirements
Module: nv_nvdla_sdp_rdma_arb

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 8, depth of the outstanding-request tag FIFO (power of 2, 2..32).
REQ-002 SHALL have port nvdla_core_clk  in  1  clock; all state on rising edge.
REQ-003 SHALL have port nvdla_core_rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports {b,n,e}_rd_req_valid  in  1, {b,n,e}_rd_req_ready  out  1, {b,n,e}_rd_req_pd  in  47: per-source read request; pd[31:0] addr, pd[46:32] size (beats-1).
REQ-005 SHALL have ports {b,n,e}_rd_rsp_valid  out  1, {b,n,e}_rd_rsp_ready  in  1, {b,n,e}_rd_rsp_pd  out  65: per-source read response.
REQ-006 SHALL have ports mc_rd_req_valid  out  1, mc_rd_req_ready  in  1, mc_rd_req_pd  out  47: shared MCIF request.
REQ-007 SHALL have ports mc_rd_rsp_valid  in  1, mc_rd_rsp_ready  out  1, mc_rd_rsp_pd  in  65: shared MCIF response, in request order.
REQ-008 SHALL have ports stall_clr  in  1 (clear perf counter) and dp2reg_arb_stall  out  32 (perf counter).

Function
REQ-009 SHALL arbitrate b/n/e round-robin; priority order starts at source after the last granted one (b->n->e->b).
REQ-010 SHALL drive mc_rd_req_valid combinationally when any source valid and tag FIFO not full; mc_rd_req_pd = granted source pd, zero extra latency.
REQ-011 SHALL lock the grant while mc_rd_req_valid=1 and mc_rd_req_ready=0; pd and selected source unchanged until handshake.
REQ-012 SHALL assert only the granted source's req_ready, equal to mc_rd_req_ready & !tag_full; others 0.
REQ-013 SHALL on request handshake push {src[1:0], size[14:0]} into tag FIFO and advance RR pointer to granted+1 in the next cycle.
REQ-014 SHALL block all requests while tag FIFO full (count==TAG_DEPTH), using pre-pop fullness even if a pop occurs the same cycle.
REQ-015 SHALL route mc_rd_rsp to source in tag FIFO head: that source's rsp_valid=mc_rd_rsp_valid, rsp_pd=mc_rd_rsp_pd, mc_rd_rsp_ready=that source's rsp_ready; combinational.
REQ-016 SHALL count accepted response beats with 15-bit beat counter; on beat where counter==head size, pop tag FIFO and clear counter, else increment.
REQ-017 SHALL hold mc_rd_rsp_ready=0 and all rsp_valid=0 while tag FIFO empty; a tag pushed in cycle N becomes routable in cycle N+1.
REQ-018 SHALL support simultaneous push and pop with count unchanged; pointers wrap modulo TAG_DEPTH.
REQ-019 SHALL never reorder responses; a stalled source's rsp_ready=0 back-pressures all MCIF responses.

Reset
REQ-020 SHALL on reset: tag FIFO empty, beat counter 0, RR pointer to b, grant lock clear, perf counter 0.
REQ-021 SHALL hold all valid/ready outputs 0 and pd outputs 0 during reset; reset mid-burst discards all outstanding tags.

Configuration
REQ-022 SHALL compile perf counter only when NVDLA_SDP_RDMA_ARB_PERF_EN defined: counter increments each cycle some source valid and no request handshake, saturates at 0xFFFFFFFF, clears on stall_clr (clear wins over increment).
REQ-023 SHALL without NVDLA_SDP_RDMA_ARB_PERF_EN tie dp2reg_arb_stall to 0 and ignore stall_clr.

Verification
REQ-024 SHALL test all three valid continuously, mc ready=1, size=0 -> grant order b,n,e,b,n,e; one request per cycle.
REQ-025 SHALL test n request size=3 then e size=0, responses 5 beats -> 4 beats on n_rd_rsp, then 1 on e_rd_rsp; tag FIFO empty after.
REQ-026 SHALL test 8 requests accepted with no responses -> 9th blocked (req_ready=0) until first response's last beat pops a tag.
REQ-027 SHALL test mc_rd_req_ready=0 for 5 cycles with b granted, n raising valid -> grant stays b, pd stable, then b handshakes.
REQ-028 SHALL test b_rd_rsp_ready=0 for 4 cycles mid-burst -> mc_rd_rsp_ready=0 for those cycles, beat counter holds, no beat lost.
REQ-029 SHALL test with PERF_EN, n valid and mc ready=0 for 10 cycles -> dp2reg_arb_stall=10; stall_clr pulse -> 0 next cycle.
